renas_mem_arbiter: RTL and testbench

Arbitrates one single-port word SRAM between the instruction-side AHB-Lite slave port (read-only) and the data-side AHB-Lite slave port (read/write). Sits between the AHB interconnect slave outputs and the main-memory SRAM macro. Handles address capture, round-robin grant, byte-lane writes, wait-state insertion and two-cycle ERROR responses.

---
 rtl/renas_mem_pkg.sv | 45 ++++
 rtl/renas_mem_port_ctrl.sv | 68 ++++++
 rtl/renas_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_renas_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/renas_mem_pkg.sv
// rtl/renas_mem_pkg.sv - shared AHB encodings, port types and byte-lane helper for the SRAM arbiter
package renas_mem_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        PEND,
        RDRSP,
        ERR1,
        ERR2
    } port_state_e;

    typedef enum logic {
        PORT_I,
        PORT_D
    } port_id_e;

    // Captured address phase; offset is relative to the SRAM base byte address.
    typedef struct packed {
        logic [31:0] offset;
        logic [2:0]  size;
        logic        write;
    } pend_t;

    // Byte enables for a write of the given size at the given byte lane.
    function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] lane);
        case (size)
            HSIZE_BYTE: byte_lanes = 4'b0001 << lane;
            HSIZE_HALF: byte_lanes = 4'b0011 << lane;
            default:    byte_lanes = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/renas_mem_port_ctrl.sv
// rtl/renas_mem_port_ctrl.sv - one AHB-Lite slave port: capture, error check, port FSM, ready/resp
module renas_mem_port_ctrl
    import renas_mem_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                MEM_DEPTH = 16384,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0400,
    parameter bit                WRITE_EN  = 1'b1
) (
    input  logic              clk_mem,
    input  logic              rst,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic [2:0]        hsize,
    input  logic              hwrite,
    input  logic              hready,
    input  logic              grant,
    output logic              hreadyout,
    output logic              hresp,
    output port_state_e       state,
    output pend_t             pend
);

    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_DEPTH * 4);

    logic [ADDR_W-1:0] offset;
    logic              range_err;
    logic              align_err;
    logic              size_err;
    logic              write_err;
    logic              bad;
    logic              take;

    assign offset    = haddr - BASE_ADDR;
    assign range_err = (haddr < BASE_ADDR) || (offset >= MEM_BYTES);
    assign align_err = ((hsize == HSIZE_HALF) && haddr[0]) ||
                       ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
    assign size_err  = (hsize > HSIZE_WORD);
    assign write_err = hwrite && !WRITE_EN;
    assign bad       = range_err || align_err || size_err || write_err;

    // A new address phase is only accepted in a cycle where this port itself is ready.
    assign take = hsel && htrans[1] && hready && hreadyout;

    // A write finishes its data phase in the grant cycle; a read waits for RDRSP.
    assign hreadyout = !(((state == PEND) && !(grant && pend.write)) || (state == ERR1));
    assign hresp     = (state == ERR1) || (state == ERR2);

    // Port FSM: capture/error check have priority, otherwise advance the response sequence.
    always_ff @(posedge clk_mem or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pend  <= '0;
        end else if (take) begin
            state <= bad ? ERR1 : PEND;
            pend  <= '{offset: 32'(offset), size: hsize, write: hwrite};
        end else begin
            case (state)
                PEND:        if (grant) state <= pend.write ? IDLE : RDRSP;
                RDRSP, ERR2: state <= IDLE;
                ERR1:        state <= ERR2;
                default:     state <= state;
            endcase
        end
    end

endmodule

// File: rtl/renas_mem_arbiter.sv
// rtl/renas_mem_arbiter.sv - round-robin arbiter of one word SRAM between AHB-Lite I and D ports
module renas_mem_arbiter
    import renas_mem_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                MEM_DEPTH = 16384,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0400,
    localparam int               SRAM_AW   = $clog2(MEM_DEPTH)
) (
    input  logic               clk_mem,
    input  logic               rst,
    input  logic               i_hsel,
    input  logic [ADDR_W-1:0]  i_haddr,
    input  logic [1:0]         i_htrans,
    input  logic [2:0]         i_hsize,
    input  logic               i_hwrite,
    input  logic               i_hready,
    output logic               i_hreadyout,
    output logic               i_hresp,
    output logic [DATA_W-1:0]  i_hrdata,
    input  logic               d_hsel,
    input  logic [ADDR_W-1:0]  d_haddr,
    input  logic [1:0]         d_htrans,
    input  logic [2:0]         d_hsize,
    input  logic               d_hwrite,
    input  logic [DATA_W-1:0]  d_hwdata,
    input  logic               d_hready,
    output logic               d_hreadyout,
    output logic               d_hresp,
    output logic [DATA_W-1:0]  d_hrdata,
    output logic               sram_cs,
    output logic               sram_we,
    output logic [3:0]         sram_be,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [DATA_W-1:0]  sram_wdata,
    input  logic [DATA_W-1:0]  sram_rdata
);

    port_state_e       i_state;
    port_state_e       d_state;
    pend_t             i_pend;
    pend_t             d_pend;
    logic              grant_i;
    logic              grant_d;
    port_id_e          last_grant;
    logic [DATA_W-1:0] i_hold;
    logic [DATA_W-1:0] d_hold;
    logic              unused_bits;

    renas_mem_port_ctrl #(
        .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR), .WRITE_EN(1'b0)
    ) u_port_i (
        .clk_mem(clk_mem), .rst(rst), .hsel(i_hsel), .haddr(i_haddr), .htrans(i_htrans),
        .hsize(i_hsize), .hwrite(i_hwrite), .hready(i_hready), .grant(grant_i),
        .hreadyout(i_hreadyout), .hresp(i_hresp), .state(i_state), .pend(i_pend)
    );

    renas_mem_port_ctrl #(
        .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR), .WRITE_EN(1'b1)
    ) u_port_d (
        .clk_mem(clk_mem), .rst(rst), .hsel(d_hsel), .haddr(d_haddr), .htrans(d_htrans),
        .hsize(d_hsize), .hwrite(d_hwrite), .hready(d_hready), .grant(grant_d),
        .hreadyout(d_hreadyout), .hresp(d_hresp), .state(d_state), .pend(d_pend)
    );

    // Single requester wins outright; on a tie the port not granted last time wins.
    always_comb begin
        grant_i = (i_state == PEND) && ((d_state != PEND) || (last_grant == PORT_D));
        grant_d = (d_state == PEND) && ((i_state != PEND) || (last_grant == PORT_I));
    end

    // Round-robin history, updated on every grant.
    always_ff @(posedge clk_mem or posedge rst) begin
        if (rst) begin
            last_grant <= PORT_I;
        end else if (grant_i) begin
            last_grant <= PORT_I;
        end else if (grant_d) begin
            last_grant <= PORT_D;
        end
    end

    // SRAM strobe is driven in the grant cycle only; idle cycles drive zeros.
    always_comb begin
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_be    = 4'b0000;
        sram_addr  = '0;
        sram_wdata = '0;
        if (grant_i) begin
            sram_cs   = 1'b1;
            sram_addr = i_pend.offset[SRAM_AW+1:2];
        end else if (grant_d) begin
            sram_cs   = 1'b1;
            sram_addr = d_pend.offset[SRAM_AW+1:2];
            if (d_pend.write) begin
                sram_we    = 1'b1;
                sram_wdata = d_hwdata;
                sram_be    = byte_lanes(d_pend.size, d_pend.offset[1:0]);
            end
        end
    end

    // Keep each port's last read word so hrdata is stable between read completions.
    always_ff @(posedge clk_mem or posedge rst) begin
        if (rst) begin
            i_hold <= '0;
            d_hold <= '0;
        end else begin
            if (i_state == RDRSP) i_hold <= sram_rdata;
            if (d_state == RDRSP) d_hold <= sram_rdata;
        end
    end

    assign i_hrdata = (i_state == RDRSP) ? sram_rdata : i_hold;
    assign d_hrdata = (d_state == RDRSP) ? sram_rdata : d_hold;

    assign unused_bits = ^{i_pend.offset[31:SRAM_AW+2], i_pend.offset[1:0], i_pend.size,
                           i_pend.write, d_pend.offset[31:SRAM_AW+2]};

endmodule

// File: tb/tb_renas_mem_arbiter.sv
// tb/tb_renas_mem_arbiter.sv - directed self-checking bench for renas_mem_arbiter
module tb_renas_mem_arbiter;
    import renas_mem_pkg::*;

    logic        clk_mem = 1'b0;
    logic        rst = 1'b1;
    logic        i_hsel = 1'b0, d_hsel = 1'b0;
    logic [31:0] i_haddr = '0, d_haddr = '0;
    logic [1:0]  i_htrans = 2'b00, d_htrans = 2'b00;
    logic [2:0]  i_hsize = 3'd2, d_hsize = 3'd2;
    logic        i_hwrite = 1'b0, d_hwrite = 1'b0;
    logic [31:0] d_hwdata = '0;
    logic        i_hready, d_hready;
    logic        i_hreadyout, d_hreadyout, i_hresp, d_hresp;
    logic [31:0] i_hrdata, d_hrdata;
    logic        sram_cs, sram_we;
    logic [3:0]  sram_be;
    logic [13:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int total = 0;
    int bad = 0;

    logic        pre_en = 1'b0;
    logic [13:0] pre_addr = '0;
    logic [31:0] pre_data = '0;
    logic [31:0] mem [0:16383];

    assign i_hready = i_hreadyout;
    assign d_hready = d_hreadyout;

    always #5 clk_mem = ~clk_mem;

    renas_mem_arbiter dut (
        .clk_mem(clk_mem), .rst(rst),
        .i_hsel(i_hsel), .i_haddr(i_haddr), .i_htrans(i_htrans), .i_hsize(i_hsize),
        .i_hwrite(i_hwrite), .i_hready(i_hready), .i_hreadyout(i_hreadyout),
        .i_hresp(i_hresp), .i_hrdata(i_hrdata),
        .d_hsel(d_hsel), .d_haddr(d_haddr), .d_htrans(d_htrans), .d_hsize(d_hsize),
        .d_hwrite(d_hwrite), .d_hwdata(d_hwdata), .d_hready(d_hready),
        .d_hreadyout(d_hreadyout), .d_hresp(d_hresp), .d_hrdata(d_hrdata),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_be(sram_be), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // SRAM macro model: byte-lane writes, one-cycle read latency, bench preload port.
    always @(posedge clk_mem) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (sram_cs) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic preload(input logic [13:0] a, input logic [31:0] d);
        @(negedge clk_mem);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk_mem);
        pre_en = 1'b0;
    endtask

    task automatic set_i(input logic sel, input logic [31:0] a, input logic [1:0] tr,
                         input logic [2:0] sz, input logic wr);
        i_hsel = sel; i_haddr = a; i_htrans = tr; i_hsize = sz; i_hwrite = wr;
    endtask

    task automatic set_d(input logic sel, input logic [31:0] a, input logic [1:0] tr,
                         input logic [2:0] sz, input logic wr);
        d_hsel = sel; d_haddr = a; d_htrans = tr; d_hsize = sz; d_hwrite = wr;
    endtask

    task automatic test_reset();
        @(negedge clk_mem); #1;
        total++;
        if ({i_hreadyout, d_hreadyout, i_hresp, d_hresp} !== 4'b1100) begin
            bad++; $display("FAIL reset_ready_resp: got %b want 1100", {i_hreadyout, d_hreadyout, i_hresp, d_hresp});
        end
        total++;
        if ({i_hrdata, d_hrdata, sram_wdata} !== 96'h0) begin
            bad++; $display("FAIL reset_data: got i=%h d=%h w=%h want 0", i_hrdata, d_hrdata, sram_wdata);
        end
        total++;
        if ({sram_cs, sram_we, sram_be, sram_addr} !== 20'h0) begin
            bad++; $display("FAIL reset_sram: got cs=%b we=%b be=%b addr=%h want 0", sram_cs, sram_we, sram_be, sram_addr);
        end
        @(negedge clk_mem);
        rst = 1'b0;
    endtask

    task automatic test_write_then_read();
        @(negedge clk_mem);
        set_d(1'b1, 32'h400, HTRANS_NONSEQ, HSIZE_WORD, 1'b1);
        @(negedge clk_mem);
        set_d(1'b0, 32'h0, HTRANS_IDLE, HSIZE_WORD, 1'b0);
        d_hwdata = 32'hDEAD_BEEF;
        #1;
        total++;
        if ({sram_cs, sram_we, sram_be, d_hreadyout} !== 7'b1111111 || sram_addr !== 14'd0 || sram_wdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL word_write: got cs=%b we=%b be=%b rdy=%b addr=%h wd=%h want 1 1 1111 1 0 deadbeef",
                            sram_cs, sram_we, sram_be, d_hreadyout, sram_addr, sram_wdata);
        end
        @(negedge clk_mem);
        d_hwdata = 32'h0;
        set_i(1'b1, 32'h400, HTRANS_NONSEQ, HSIZE_WORD, 1'b0);
        @(negedge clk_mem);
        set_i(1'b0, 32'h0, HTRANS_IDLE, HSIZE_WORD, 1'b0);
        #1;
        total++;
        if ({i_hreadyout, sram_cs, sram_we} !== 3'b010 || sram_addr !== 14'd0) begin
            bad++; $display("FAIL i_read_grant: got rdy=%b cs=%b we=%b addr=%h want 0 1 0 0", i_hreadyout, sram_cs, sram_we, sram_addr);
        end
        @(negedge clk_mem); #1;
        total++;
        if (i_hreadyout !== 1'b1 || i_hresp !== 1'b0 || i_hrdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL i_read_data: got rdy=%b resp=%b data=%h want 1 0 deadbeef", i_hreadyout, i_hresp, i_hrdata);
        end
        @(negedge clk_mem); #1;
        total++;
        if (i_hrdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL i_hrdata_hold: got %h want deadbeef", i_hrdata);
        end
    endtask

    task automatic test_byte_write();
        @(negedge clk_mem);
        set_d(1'b1, 32'h406, HTRANS_NONSEQ, HSIZE_BYTE, 1'b1);
        @(negedge clk_mem);
        set_d(1'b0, 32'h0, HTRANS_IDLE, HSIZE_WORD, 1'b0);
        d_hwdata = 32'h00AA_0000;
        #1;
        total++;
        if (sram_addr !== 14'd1 || sram_be !== 4'b0100 || sram_we !== 1'b1) begin
            bad++; $display("FAIL byte_write: got addr=%h be=%b we=%b want 1 0100 1", sram_addr, sram_be, sram_we);
        end
        @(negedge clk_mem);
        d_hwdata = 32'h0;
        set_d(1'b1, 32'h404, HTRANS_NONSEQ, HSIZE_WORD, 1'b0);
        @(negedge clk_mem);
        set_d(1'b0, 32'h0, HTRANS_IDLE, HSIZE_WORD, 1'b0);
        #1;
        total++;
        if (d_hreadyout !== 1'b0) begin
            bad++; $display("FAIL d_read_wait: got rdy=%b want 0", d_hreadyout);
        end
        @(negedge clk_mem); #1;
        total++;
        if (d_hrdata !== 32'h11AA_3344 || d_hreadyout !== 1'b1) begin
            bad++; $display("FAIL byte_merge: got data=%h rdy=%b want 11aa3344 1", d_hrdata, d_hreadyout);
        end
    endtask

    task automatic test_tie();
        @(negedge clk_mem); rst = 1'b1;
        @(negedge clk_mem); rst = 1'b0;
        @(negedge clk_mem);
        set_i(1'b1, 32'h408, HTRANS_NONSEQ, HSIZE_WORD, 1'b0);
        set_d(1'b1, 32'h40C, HTRANS_NONSEQ, HSIZE_WORD, 1'b0);
        @(negedge clk_mem);
        set_i(1'b0, 32'h0, HTRANS_IDLE, HSIZE_WORD, 1'b0);
        set_d(1'b0, 32'h0, HTRANS_IDLE, HSIZE_WORD, 1'b0);
        #1;
        total++;
        if (sram_addr !== 14'd3 || {sram_cs, i_hreadyout, d_hreadyout} !== 3'b100) begin
            bad++; $display("FAIL tie1_a1: got addr=%h cs/irdy/drdy=%b want 3 100", sram_addr, {sram_cs, i_hreadyout, d_hreadyout});
        end
        @(negedge clk_mem); #1;
        total++;
        if (sram_addr !== 14'd2 || {sram_cs, i_hreadyout, d_hreadyout} !== 3'b101 || d_hrdata !== 32'h5A5A_0003) begin
            bad++; $display("FAIL tie1_a2: got addr=%h cs/irdy/drdy=%b d=%h want 2 101 5a5a0003",
                            sram_addr, {sram_cs, i_hreadyout, d_hreadyout}, d_hrdata);
        end
        @(negedge clk_mem); #1;
        total++;
        if (i_hreadyout !== 1'b1 || i_hrdata !== 32'hA5A5_0002) begin
            bad++; $display("FAIL tie1_a3: got rdy=%b i=%h want 1 a5a50002", i_hreadyout, i_hrdata);
        end
        set_d(1'b1, 32'h40C, HTRANS_NONSEQ, HSIZE_WORD, 1'b0);
        @(negedge clk_mem);
        set_d(1'b0, 32'h0, HTRANS_IDLE, HSIZE_WORD, 1'b0);
        @(negedge clk_mem);
        set_i(1'b1, 32'h408, HTRANS_NONSEQ, HSIZE_WORD, 1'b0);
        set_d(1'b1, 32'h40C, HTRANS_NONSEQ, HSIZE_WORD, 1'b0);
        @(negedge clk_mem);
        set_i(1'b0, 32'h0, HTRANS_IDLE, HSIZE_WORD, 1'b0);
        set_d(1'b0, 32'h0, HTRANS_IDLE, HSIZE_WORD, 1'b0);
        #1;
        total++;
        if (sram_addr !== 14'd2 || {i_hreadyout, d_hreadyout} !== 2'b00) begin
            bad++; $display("FAIL tie2_i_first: got addr=%h rdy=%b want 2 00", sram_addr, {i_hreadyout, d_hreadyout});
        end
        @(negedge clk_mem);
        @(negedge clk_mem); #1;
        total++;
        if (d_hrdata !== 32'h5A5A_0003 || d_hreadyout !== 1'b1) begin
            bad++; $display("FAIL tie2_d_data: got d=%h rdy=%b want 5a5a0003 1", d_hrdata, d_hreadyout);
        end
    endtask

    task automatic test_errors();
        logic        eport [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] eaddr [4] = '{32'h400, 32'h3FC, 32'h0001_0400, 32'h401};
        logic [2:0]  esize [4] = '{HSIZE_WORD, HSIZE_WORD, HSIZE_WORD, HSIZE_HALF};
        logic        ewr   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_mem);
            if (eport[k]) set_d(1'b1, eaddr[k], HTRANS_NONSEQ, esize[k], ewr[k]);
            else          set_i(1'b1, eaddr[k], HTRANS_NONSEQ, esize[k], ewr[k]);
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk_mem);
                set_i(1'b0, 32'h0, HTRANS_IDLE, HSIZE_WORD, 1'b0);
                set_d(1'b0, 32'h0, HTRANS_IDLE, HSIZE_WORD, 1'b0);
                #1;
                total++;
                if ({(eport[k] ? d_hreadyout : i_hreadyout), (eport[k] ? d_hresp : i_hresp), sram_cs} !==
                    {(c != 1), (c != 3), 1'b0}) begin
                    bad++; $display("FAIL err_case%0d_cycle%0d: got rdy/resp/cs=%b want %b", k, c,
                                    {(eport[k] ? d_hreadyout : i_hreadyout), (eport[k] ? d_hresp : i_hresp), sram_cs},
                                    {(c != 1), (c != 3), 1'b0});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk_mem);
        set_d(1'b1, 32'h408, HTRANS_NONSEQ, HSIZE_WORD, 1'b0);
        @(negedge clk_mem);
        set_d(1'b0, 32'h0, HTRANS_IDLE, HSIZE_WORD, 1'b0);
        rst = 1'b1;
        #1;
        total++;
        if ({sram_cs, d_hreadyout, d_hresp} !== 3'b010 || d_hrdata !== 32'h0 || i_hrdata !== 32'h0) begin
            bad++; $display("FAIL mid_reset: got cs/rdy/resp=%b d=%h i=%h want 010 0 0",
                            {sram_cs, d_hreadyout, d_hresp}, d_hrdata, i_hrdata);
        end
        @(negedge clk_mem); rst = 1'b0;
        @(negedge clk_mem); #1;
        total++;
        if ({sram_cs, d_hreadyout} !== 2'b01 || d_hrdata !== 32'h0) begin
            bad++; $display("FAIL after_reset: got cs/rdy=%b d=%h want 01 0", {sram_cs, d_hreadyout}, d_hrdata);
        end
        set_d(1'b1, 32'h404, HTRANS_NONSEQ, HSIZE_WORD, 1'b0);
        @(negedge clk_mem);
        set_d(1'b0, 32'h0, HTRANS_IDLE, HSIZE_WORD, 1'b0);
        #1;
        total++;
        if (sram_cs !== 1'b1 || sram_addr !== 14'd1) begin
            bad++; $display("FAIL fresh_grant: got cs=%b addr=%h want 1 1", sram_cs, sram_addr);
        end
        @(negedge clk_mem); #1;
        total++;
        if (d_hrdata !== 32'h11AA_3344 || d_hreadyout !== 1'b1) begin
            bad++; $display("FAIL fresh_read: got d=%h rdy=%b want 11aa3344 1", d_hrdata, d_hreadyout);
        end
    endtask

    task automatic test_stream();
        @(negedge clk_mem);
        set_i(1'b1, 32'h420, HTRANS_NONSEQ, HSIZE_WORD, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_mem);
            if (k < 7) set_i(1'b1, 32'h420 + 32'(4 * (k + 1)), HTRANS_SEQ, HSIZE_WORD, 1'b0);
            else       set_i(1'b0, 32'h0, HTRANS_IDLE, HSIZE_WORD, 1'b0);
            #1;
            total++;
            if (i_hreadyout !== 1'b0 || sram_addr !== 14'(8 + k)) begin
                bad++; $display("FAIL stream_grant%0d: got rdy=%b addr=%h want 0 %h", k, i_hreadyout, sram_addr, 14'(8 + k));
            end
            @(negedge clk_mem); #1;
            total++;
            if (i_hreadyout !== 1'b1 || i_hrdata !== 32'hC0DE_0000 + 32'(k)) begin
                bad++; $display("FAIL stream_word%0d: got rdy=%b data=%h want 1 %h", k, i_hreadyout, i_hrdata, 32'hC0DE_0000 + 32'(k));
            end
        end
    endtask

    initial begin
        preload(14'd1, 32'h1122_3344);
        preload(14'd2, 32'hA5A5_0002);
        preload(14'd3, 32'h5A5A_0003);
        for (int k = 0; k < 8; k++) preload(14'(8 + k), 32'hC0DE_0000 + 32'(k));
        test_reset();
        test_write_then_read();
        test_byte_write();
        test_tie();
        test_errors();
        test_reset_mid();
        test_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
